// File: rtl/mem_pkg.sv
// Shared definitions for the MEMORY-section switch-style storage blocks:
// controller state encoding and the per-bit switched-inverter step.
package mem_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } bank_state_e;

  // One bit of a switched inverter: passes d (optionally inverted) when loaded, else drives 0.
  function automatic logic switch_inv(input logic i_d, input logic i_load, input logic i_inv);
    return i_load & (i_d ^ i_inv);
  endfunction

endpackage

// File: rtl/read_port_gate.sv
// One read port of the register bank: same-cycle write bypass, per-port
// inversion and load gating, followed by the output register.
module read_port_gate
  import mem_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_inv,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WIDTH-1:0]  i_mem_data,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  output logic [WIDTH-1:0]  o_data
);

  logic [WIDTH-1:0] w_rdata;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] r_out;

  // Bypass the array when this cycle's write targets the address being read.
  always_comb begin
    w_rdata = i_mem_data;
    if (i_wr_en && (i_wr_addr == i_addr)) begin
      w_rdata = i_wr_data;
    end else begin
      w_rdata = i_mem_data;
    end
    w_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_next[i] = switch_inv(w_rdata[i], i_load, i_inv);
    end
  end

  // Output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= '0;
    end else begin
      r_out <= w_next;
    end
  end

  assign o_data = r_out;

endmodule

// File: rtl/reg_bank_switch.sv
// DEPTH x WIDTH register bank with one save port, two switch-gated read
// ports and a one-word-per-cycle clear sequencer.
module reg_bank_switch
  import mem_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              save,
  input  logic [ADDR_W-1:0] save_addr,
  input  logic [WIDTH-1:0]  save_data,
  input  logic              load_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic              inv_a,
  input  logic              load_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic              inv_b,
  input  logic              clear,
  output logic [WIDTH-1:0]  out_a,
  output logic [WIDTH-1:0]  out_b,
  output logic              busy
);

  bank_state_e      r_state;
  bank_state_e      w_state_next;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_next;
  logic [WIDTH-1:0]  r_mem [DEPTH];

  logic              w_save_acc;
  logic              w_clr_we;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [WIDTH-1:0]  w_wr_data;

  // A single write port shared by the save path and the clear engine; saves only land in IDLE.
  assign w_save_acc = save && (r_state == IDLE);
  assign w_clr_we   = (r_state == CLEAR);
  assign w_wr_en    = w_save_acc | w_clr_we;
  assign w_wr_addr  = w_clr_we ? r_cnt : save_addr;
  assign w_wr_data  = w_clr_we ? '0 : save_data;
  assign busy       = (r_state == CLEAR);

  // Clear sequencer next-state logic.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (clear) begin
          w_state_next = CLEAR;
          w_cnt_next   = '0;
        end else begin
          w_state_next = IDLE;
          w_cnt_next   = r_cnt;
        end
      end
      CLEAR: begin
        w_cnt_next = r_cnt + ADDR_W'(1);
        if (r_cnt == ADDR_W'(DEPTH - 1)) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = CLEAR;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Sequencer state and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Storage array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[w_wr_addr] <= w_wr_data;
    end
  end

  read_port_gate #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_port_a (
    .clk        (clk),
    .rst        (rst),
    .i_load     (load_a),
    .i_inv      (inv_a),
    .i_addr     (addr_a),
    .i_mem_data (r_mem[addr_a]),
    .i_wr_en    (w_wr_en),
    .i_wr_addr  (w_wr_addr),
    .i_wr_data  (w_wr_data),
    .o_data     (out_a)
  );

  read_port_gate #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_port_b (
    .clk        (clk),
    .rst        (rst),
    .i_load     (load_b),
    .i_inv      (inv_b),
    .i_addr     (addr_b),
    .i_mem_data (r_mem[addr_b]),
    .i_wr_en    (w_wr_en),
    .i_wr_addr  (w_wr_addr),
    .i_wr_data  (w_wr_data),
    .o_data     (out_b)
  );

endmodule

// File: tb/tb_reg_bank_switch.sv
// Directed self-checking bench for reg_bank_switch (WIDTH=8, DEPTH=8).
module tb_reg_bank_switch;

  logic       clk = 1'b0;
  logic       rst;
  logic       save;
  logic [2:0] save_addr;
  logic [7:0] save_data;
  logic       load_a, load_b, inv_a, inv_b, clear;
  logic [2:0] addr_a, addr_b;
  logic [7:0] out_a, out_b;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_busy;

  reg_bank_switch #(.WIDTH(8), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .save(save), .save_addr(save_addr), .save_data(save_data),
    .load_a(load_a), .addr_a(addr_a), .inv_a(inv_a),
    .load_b(load_b), .addr_b(addr_b), .inv_b(inv_b),
    .clear(clear), .out_a(out_a), .out_b(out_b), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_save(input logic [2:0] a, input logic [7:0] d);
    save = 1'b1; save_addr = a; save_data = d;
    tick();
    save = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; save = 1'b0; save_addr = 3'd0; save_data = 8'h00;
    load_a = 1'b0; load_b = 1'b0; inv_a = 1'b0; inv_b = 1'b0;
    addr_a = 3'd0; addr_b = 3'd0; clear = 1'b0;
    tick(); tick();
    check("rst_out_a", {24'd0, out_a}, 32'h00);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    // reset then read
    load_a = 1'b1; addr_a = 3'd3;
    tick();
    check("read_after_rst", {24'd0, out_a}, 32'h00);
    check("busy_idle", {31'd0, busy}, 32'd0);
    load_a = 1'b0;

    // save / load / invert
    do_save(3'd2, 8'h5A);
    load_a = 1'b1; addr_a = 3'd2; inv_a = 1'b0;
    load_b = 1'b1; addr_b = 3'd2; inv_b = 1'b1;
    tick();
    check("load_a_plain", {24'd0, out_a}, 32'h5A);
    check("load_b_inv", {24'd0, out_b}, 32'hA5);
    load_a = 1'b0;
    tick();
    check("gate_a_off", {24'd0, out_a}, 32'h00);
    check("b_still_on", {24'd0, out_b}, 32'hA5);

    // bypass: old value 0x77 must not appear
    load_b = 1'b0;
    do_save(3'd5, 8'h77);
    save = 1'b1; save_addr = 3'd5; save_data = 8'h3C;
    load_a = 1'b1; addr_a = 3'd5; inv_a = 1'b0;
    load_b = 1'b1; addr_b = 3'd5; inv_b = 1'b1;
    tick();
    save = 1'b0;
    check("bypass_a", {24'd0, out_a}, 32'h3C);
    check("bypass_b_inv", {24'd0, out_b}, 32'hC3);
    tick();
    check("after_bypass_a", {24'd0, out_a}, 32'h3C);
    load_a = 1'b0; load_b = 1'b0;

    // clear sequence over a full bank
    for (int i = 0; i < 8; i++) do_save(3'(i), 8'hFF);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_busy = 0;
    while (busy && n_busy < 20) begin
      n_busy++;
      if (n_busy == 3) begin
        load_a = 1'b1; addr_a = 3'd7; inv_a = 1'b0;
        load_b = 1'b1; addr_b = 3'd2; inv_b = 1'b0;
      end else begin
        load_a = 1'b0; load_b = 1'b0;
      end
      if (n_busy == 4) begin
        save = 1'b1; save_addr = 3'd0; save_data = 8'h11;
        clear = 1'b1;
      end else begin
        save = 1'b0; clear = 1'b0;
      end
      tick();
      if (n_busy == 3) begin
        check("clr_not_yet", {24'd0, out_a}, 32'hFF);
        check("clr_bypass_cur", {24'd0, out_b}, 32'h00);
      end
    end
    save = 1'b0; clear = 1'b0; load_a = 1'b0; load_b = 1'b0;
    check("busy_len", n_busy, 32'd8);
    check("busy_fell", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      load_a = 1'b1; addr_a = 3'(i); inv_a = 1'b0;
      load_b = 1'b1; addr_b = 3'(i); inv_b = 1'b1;
      tick();
      check($sformatf("cleared_a_%0d", i), {24'd0, out_a}, 32'h00);
      check($sformatf("cleared_b_%0d", i), {24'd0, out_b}, 32'hFF);
    end
    load_a = 1'b0; load_b = 1'b0;
    tick();
    check("clear_ignored_busy", {31'd0, busy}, 32'd0);

    // save and clear in the same IDLE cycle: save lands first
    save = 1'b1; save_addr = 3'd4; save_data = 8'h24; clear = 1'b1;
    tick();
    save = 1'b0; clear = 1'b0;
    check("save_clr_busy", {31'd0, busy}, 32'd1);
    load_a = 1'b1; addr_a = 3'd4; inv_a = 1'b0;
    tick();
    check("save_then_clear", {24'd0, out_a}, 32'h24);
    load_a = 1'b0;
    wait_idle("save_clr_idle");

    // reset mid-clear
    do_save(3'd1, 8'h42);
    do_save(3'd6, 8'h99);
    load_a = 1'b1; addr_a = 3'd6; inv_a = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick(); tick();
    check("pre_rst_old", {24'd0, out_a}, 32'h99);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_out_a", {24'd0, out_a}, 32'h00);
    tick();
    rst = 1'b0;
    load_b = 1'b1; addr_b = 3'd1; inv_b = 1'b0;
    tick();
    check("post_rst_w6", {24'd0, out_a}, 32'h00);
    check("post_rst_w1", {24'd0, out_b}, 32'h00);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
